// File: rtl/watch_pkg.sv
// Shared types and constants for the watch controller: mode encodings,
// edit cursor positions, BCD digit limits and the display width helper.
package watch_pkg;

  typedef enum logic [2:0] {
    MODE_CLOCK     = 3'd0,
    MODE_ALARM     = 3'd1,
    MODE_STOPWATCH = 3'd2,
    MODE_SET_CLOCK = 3'd3,
    MODE_SET_ALARM = 3'd4
  } mode_e;

  // Edit cursor, leftmost digit first
  localparam logic [1:0] CUR_HT = 2'd0;
  localparam logic [1:0] CUR_HO = 2'd1;
  localparam logic [1:0] CUR_MT = 2'd2;
  localparam logic [1:0] CUR_MO = 2'd3;

  // BCD digit limits for a 24h time
  localparam logic [3:0] HT_MAX    = 4'd2;
  localparam logic [3:0] HO_MAX    = 4'd9;
  localparam logic [3:0] HO_MAX_20 = 4'd3;  // hour ones limit once hour tens is 2
  localparam logic [3:0] MT_MAX    = 4'd5;
  localparam logic [3:0] MO_MAX    = 4'd9;
  localparam logic [3:0] ST_MAX    = 4'd5;
  localparam logic [3:0] SO_MAX    = 4'd9;

  typedef struct packed {
    logic [3:0] ht;
    logic [3:0] ho;
    logic [3:0] mt;
    logic [3:0] mo;
  } hhmm_t;

  typedef struct packed {
    hhmm_t      hm;
    logic [3:0] st;
    logic [3:0] so;
  } bcdTime_t;

  function automatic int digitsWidth(input int numDigits);
    return 4 * numDigits;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// BCD HH:MM:SS counter with synchronous load. MAX_HOURS sets the hour
// wrap point (23 for time of day, 99 for a stopwatch, 0 to pin hours
// at zero); MAX_MINUTES = 99 lets the minutes field run 00..99.
module bcd_time_counter
  import watch_pkg::*;
#(
  parameter int MAX_HOURS   = 23,
  parameter int MAX_MINUTES = 59
) (
  input  logic     clk,
  input  logic     resetN,
  input  logic     inc,
  input  logic     load,
  input  bcdTime_t loadValue,
  output bcdTime_t value,
  output bcdTime_t nextValue,
  output logic     carry
);

  localparam logic [3:0] MT_TOP = (MAX_MINUTES == 99) ? 4'd9 : MT_MAX;
  localparam logic [3:0] HT_TOP = 4'(MAX_HOURS / 10);
  localparam logic [3:0] HO_TOP = 4'(MAX_HOURS % 10);

  logic soEnd, stEnd, moEnd, mtEnd, hEnd;

  // Ripple the +1 second through the BCD fields
  always_comb begin
    soEnd = (value.so == SO_MAX);
    stEnd = soEnd && (value.st == ST_MAX);
    moEnd = stEnd && (value.hm.mo == MO_MAX);
    mtEnd = moEnd && (value.hm.mt == MT_TOP);
    hEnd  = (value.hm.ht == HT_TOP) && (value.hm.ho == HO_TOP);
    nextValue    = value;
    nextValue.so = soEnd ? 4'd0 : value.so + 4'd1;
    if (soEnd) nextValue.st    = stEnd ? 4'd0 : value.st + 4'd1;
    if (stEnd) nextValue.hm.mo = moEnd ? 4'd0 : value.hm.mo + 4'd1;
    if (moEnd) nextValue.hm.mt = mtEnd ? 4'd0 : value.hm.mt + 4'd1;
    if (mtEnd) begin
      if (hEnd) begin
        nextValue.hm.ht = 4'd0;
        nextValue.hm.ho = 4'd0;
      end else if (value.hm.ho == 4'd9) begin
        nextValue.hm.ht = value.hm.ht + 4'd1;
        nextValue.hm.ho = 4'd0;
      end else begin
        nextValue.hm.ho = value.hm.ho + 4'd1;
      end
    end
  end

  assign carry = inc && mtEnd && hEnd;

  // Load has priority over counting
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)   value <= '0;
    else if (load) value <= loadValue;
    else if (inc)  value <= nextValue;
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: time of day, alarm, background stopwatch and a
// cursor-based HH:MM editor behind one mode FSM. Drives BCD digits plus
// a per-digit blink mask to the seven-segment decoders.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int NUM_DIGITS   = 4,
  parameter int BEEP_SECONDS = 60
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                modeNext,
  input  logic                                setValue,
  input  logic                                nextDigit,
  input  logic                                upTime,
  input  logic                                startStop,
  input  logic                                lapReset,
  output logic [digitsWidth(NUM_DIGITS)-1:0]  displayDigits,
  output logic [NUM_DIGITS-1:0]               blinkMask,
  output logic [2:0]                          modeState,
  output logic                                alarmEnabled,
  output logic                                alarmBeep
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BEEP_SECONDS + 1);
  localparam logic [NUM_DIGITS-1:0] MSB_BIT = {1'b1, {(NUM_DIGITS-1){1'b0}}};

  mode_e          mode, modeNxt;
  logic [PW-1:0]  presc;
  logic           blinkPhase, secTick, prescClr;
  logic           anyBtn, btnOk, doSet, doMode, doNext, doUp, doStart, doLap;
  logic           inSet, todLoad, swClear, alarmHit;
  hhmm_t          shadow, shadowUp, alarmTime;
  logic [1:0]     cursor;
  logic           swRun, swLapOn;
  bcdTime_t       swLap, todValue, todNext, swValue, swNext, shown;
  logic [BW-1:0]  beepCnt;
  logic           todCarry, swCarry;

  assign secTick = (presc == PW'(TICK_DIV - 1));

  // Seconds prescaler; blink phase runs at 1 Hz, cleared with the prescaler
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc      <= '0;
      blinkPhase <= 1'b0;
    end else if (prescClr) begin
      presc      <= '0;
      blinkPhase <= 1'b0;
    end else begin
      presc <= secTick ? '0 : presc + PW'(1);
      if (secTick || presc == PW'(TICK_DIV / 2 - 1)) blinkPhase <= ~blinkPhase;
    end
  end

  // One winning button per cycle; any pulse during a beep only silences it
  always_comb begin
    anyBtn  = setValue | modeNext | nextDigit | upTime | startStop | lapReset;
    btnOk   = !alarmBeep;
    doSet   = btnOk && setValue;
    doMode  = btnOk && !setValue && modeNext;
    doNext  = btnOk && !setValue && !modeNext && nextDigit;
    doUp    = btnOk && !setValue && !modeNext && !nextDigit && upTime;
    doStart = btnOk && !setValue && !modeNext && !nextDigit && !upTime && startStop;
    doLap   = btnOk && !setValue && !modeNext && !nextDigit && !upTime && !startStop && lapReset;
  end

  // Mode state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) mode <= MODE_CLOCK;
    else         mode <= modeNxt;
  end

  // Mode transitions
  always_comb begin
    modeNxt = mode;
    case (mode)
      MODE_CLOCK:     if (doSet) modeNxt = MODE_SET_CLOCK; else if (doMode) modeNxt = MODE_ALARM;
      MODE_ALARM:     if (doSet) modeNxt = MODE_SET_ALARM; else if (doMode) modeNxt = MODE_STOPWATCH;
      MODE_STOPWATCH: if (doMode) modeNxt = MODE_CLOCK;
      MODE_SET_CLOCK: if (doSet) modeNxt = MODE_CLOCK;
      MODE_SET_ALARM: if (doSet) modeNxt = MODE_ALARM;
      default:        modeNxt = MODE_CLOCK;
    endcase
  end

  assign inSet    = (mode == MODE_SET_CLOCK) || (mode == MODE_SET_ALARM);
  assign todLoad  = doSet && (mode == MODE_SET_CLOCK);
  assign prescClr = todLoad;
  assign swClear  = doLap && (mode == MODE_STOPWATCH) && !swRun;
  assign alarmHit = secTick && alarmEnabled && (mode != MODE_SET_CLOCK) &&
                    (todNext.hm == alarmTime) && (todNext.st == 4'd0) && (todNext.so == 4'd0);

  bcd_time_counter #(.MAX_HOURS(23), .MAX_MINUTES(59)) uTod (
    .clk(clk), .resetN(resetN), .inc(secTick), .load(todLoad),
    .loadValue({shadow, 8'h00}), .value(todValue), .nextValue(todNext), .carry(todCarry)
  );

  bcd_time_counter #(
    .MAX_HOURS  ((NUM_DIGITS == 6) ? 99 : 0),
    .MAX_MINUTES((NUM_DIGITS == 6) ? 59 : 99)
  ) uSw (
    .clk(clk), .resetN(resetN), .inc(secTick && swRun), .load(swClear),
    .loadValue('0), .value(swValue), .nextValue(swNext), .carry(swCarry)
  );

  // Cursor digit +1 with wrap; hour tens reaching 2 clamps hour ones to 3
  always_comb begin
    shadowUp = shadow;
    case (cursor)
      CUR_HT: begin
        shadowUp.ht = (shadow.ht >= HT_MAX) ? 4'd0 : shadow.ht + 4'd1;
        if (shadowUp.ht == HT_MAX && shadow.ho > HO_MAX_20) shadowUp.ho = HO_MAX_20;
      end
      CUR_HO:  shadowUp.ho = (shadow.ho >= ((shadow.ht == HT_MAX) ? HO_MAX_20 : HO_MAX)) ?
                             4'd0 : shadow.ho + 4'd1;
      CUR_MT:  shadowUp.mt = (shadow.mt >= MT_MAX) ? 4'd0 : shadow.mt + 4'd1;
      default: shadowUp.mo = (shadow.mo >= MO_MAX) ? 4'd0 : shadow.mo + 4'd1;
    endcase
  end

  // Editor shadow, cursor and alarm time/arm
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow       <= '0;
      cursor       <= CUR_HT;
      alarmTime    <= '0;
      alarmEnabled <= 1'b0;
    end else begin
      if (doSet && mode == MODE_CLOCK) begin
        shadow <= todValue.hm;
        cursor <= CUR_HT;
      end
      if (doSet && mode == MODE_ALARM) begin
        shadow <= alarmTime;
        cursor <= CUR_HT;
      end
      if (doSet && mode == MODE_SET_ALARM) alarmTime <= shadow;
      if (inSet && doNext) cursor <= cursor + 2'd1;
      if (inSet && doUp)   shadow <= shadowUp;
      if (mode == MODE_ALARM && doUp) alarmEnabled <= ~alarmEnabled;
    end
  end

  // Stopwatch run and lap freeze
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      swRun   <= 1'b0;
      swLapOn <= 1'b0;
      swLap   <= '0;
    end else if (mode == MODE_STOPWATCH) begin
      if (doStart) swRun <= ~swRun;
      if (doLap) begin
        if (swRun) begin
          swLapOn <= ~swLapOn;
          swLap   <= swValue;
        end else begin
          swLapOn <= 1'b0;
        end
      end
    end
  end

  // Beep: set after the trigger tick, cleared by timeout, button or disarm
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      alarmBeep <= 1'b0;
      beepCnt   <= '0;
    end else if (alarmHit) begin
      alarmBeep <= 1'b1;
      beepCnt   <= '0;
    end else if (alarmBeep) begin
      if (anyBtn || !alarmEnabled) begin
        alarmBeep <= 1'b0;
      end else if (secTick) begin
        if (beepCnt == BW'(BEEP_SECONDS - 1)) alarmBeep <= 1'b0;
        beepCnt <= beepCnt + BW'(1);
      end
    end
  end

  // Per-mode display source and cursor blink
  always_comb begin
    case (mode)
      MODE_ALARM:                     shown = {alarmTime, 8'h00};
      MODE_STOPWATCH:                 shown = swLapOn ? swLap : swValue;
      MODE_SET_CLOCK, MODE_SET_ALARM: shown = {shadow, 8'h00};
      default:                        shown = todValue;
    endcase
    blinkMask = (inSet && blinkPhase) ? (MSB_BIT >> cursor) : '0;
  end

  generate
    if (NUM_DIGITS == 6) begin : gSix
      assign displayDigits = shown;
    end else begin : gFour
      // Four digits show MM:SS for the stopwatch, HH:MM otherwise
      assign displayDigits = (mode == MODE_STOPWATCH) ?
                             {shown.hm.mt, shown.hm.mo, shown.st, shown.so} : shown.hm;
    end
  endgenerate

  assign modeState = mode;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench: a 4-digit and a 6-digit controller share one stimulus
// stream, so time-of-day, alarm and stopwatch state match and only the
// digit formatting differs. TICK_DIV = 4: one second every 4 clocks.
module tb_watch_mode_ctrl;

  localparam logic [5:0] B_SET  = 6'b100000;
  localparam logic [5:0] B_MODE = 6'b010000;
  localparam logic [5:0] B_NEXT = 6'b001000;
  localparam logic [5:0] B_UP   = 6'b000100;
  localparam logic [5:0] B_SS   = 6'b000010;
  localparam logic [5:0] B_LAP  = 6'b000001;

  logic clk = 1'b0, resetN = 1'b1;
  logic modeNext = 1'b0, setValue = 1'b0, nextDigit = 1'b0;
  logic upTime = 1'b0, startStop = 1'b0, lapReset = 1'b0;
  logic [15:0] disp4;
  logic [23:0] disp6;
  logic [3:0]  blink4;
  logic [5:0]  blink6;
  logic [2:0]  mode4, mode6;
  logic        alEn4, alEn6, beep4, beep6;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  watch_mode_ctrl #(.TICK_DIV(4), .NUM_DIGITS(4), .BEEP_SECONDS(60)) dut4 (
    .clk(clk), .resetN(resetN), .modeNext(modeNext), .setValue(setValue),
    .nextDigit(nextDigit), .upTime(upTime), .startStop(startStop), .lapReset(lapReset),
    .displayDigits(disp4), .blinkMask(blink4), .modeState(mode4),
    .alarmEnabled(alEn4), .alarmBeep(beep4)
  );

  watch_mode_ctrl #(.TICK_DIV(4), .NUM_DIGITS(6), .BEEP_SECONDS(60)) dut6 (
    .clk(clk), .resetN(resetN), .modeNext(modeNext), .setValue(setValue),
    .nextDigit(nextDigit), .upTime(upTime), .startStop(startStop), .lapReset(lapReset),
    .displayDigits(disp6), .blinkMask(blink6), .modeState(mode6),
    .alarmEnabled(alEn6), .alarmBeep(beep6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive buttons for exactly one rising edge, starting from a falling edge
  task automatic press(input logic [5:0] b);
    {setValue, modeNext, nextDigit, upTime, startStop, lapReset} = b;
    @(negedge clk);
    {setValue, modeNext, nextDigit, upTime, startStop, lapReset} = 6'b0;
  endtask

  task automatic pressN(input logic [5:0] b, input int n);
    repeat (n) press(b);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, " disp4"}, 32'(disp4), 32'h0);
    chk({tag, " disp6"}, 32'(disp6), 32'h0);
    chk({tag, " blink"}, 32'({blink4, blink6}), 32'h0);
    chk({tag, " mode"},  32'({mode4, mode6}), 32'h0);
    chk({tag, " alarm"}, 32'({alEn4, alEn6, beep4, beep6}), 32'h0);
  endtask

  initial begin
    #1 resetN = 1'b0;
    #7 chkAllZero("por");
    @(negedge clk) resetN = 1'b1;

    // Arm the alarm, then set 12:34 and run to 12:34:56
    press(B_MODE);
    press(B_UP);
    chk("arm", 32'({alEn4, alEn6}), 32'h3);
    pressN(B_MODE, 2);
    press(B_SET);
    press(B_UP);
    press(B_NEXT); pressN(B_UP, 2);
    press(B_NEXT); pressN(B_UP, 3);
    press(B_NEXT); pressN(B_UP, 4);
    chk("shadow 1234", 32'(disp4), 32'h1234);
    press(B_SET);
    cyc(224);
    chk("time 123456", 32'(disp6), 32'h123456);
    press(B_MODE);
    chk("mode alarm", 32'(mode4), 32'd1);

    // Asynchronous reset mid-cycle
    #2 resetN = 1'b0;
    #1 chkAllZero("async rst");
    @(negedge clk) resetN = 1'b1;
    chk("post rst disp4", 32'(disp4), 32'h0);

    // setValue beats modeNext in the same cycle
    press(B_SET | B_MODE);
    chk("set+mode", 32'(mode4), 32'd3);
    chk("blink off phase", 32'(blink4), 32'h0);
    cyc(1);
    chk("blink4 cur0", 32'(blink4), 32'h8);
    chk("blink6 cur0", 32'(blink6), 32'h20);
    press(B_NEXT);
    chk("blink4 cur1", 32'(blink4), 32'h4);

    // Hour ones to 9, hour tens to 2 clamps ones to 3
    pressN(B_UP, 9);
    chk("shadow 0900", 32'(disp4), 32'h0900);
    pressN(B_NEXT, 3);
    pressN(B_UP, 2);
    chk("clamp 2300", 32'(disp4), 32'h2300);
    press(B_NEXT);
    press(B_UP);
    chk("ho wrap 2000", 32'(disp4), 32'h2000);
    pressN(B_UP, 3);
    press(B_SET);
    chk("commit mode", 32'(mode4), 32'd0);
    chk("commit 2300", 32'(disp4), 32'h2300);
    chk("commit ss0", 32'(disp6), 32'h230000);

    // Set 23:59, checking minute tens wrap, then roll past midnight
    press(B_SET);
    pressN(B_NEXT, 2);
    pressN(B_UP, 6);
    chk("mt wrap", 32'(disp4), 32'h2300);
    pressN(B_UP, 5);
    press(B_NEXT);
    pressN(B_UP, 9);
    chk("shadow 2359", 32'(disp4), 32'h2359);
    press(B_SET);
    chk("blink clock", 32'({blink4, blink6}), 32'h0);
    cyc(236);
    chk("time 235959", 32'(disp6), 32'h235959);
    cyc(4);
    chk("midnight6", 32'(disp6), 32'h000000);
    chk("midnight4", 32'(disp4), 32'h0000);
    chk("no beep disarmed", 32'(beep4), 32'h0);

    // Alarm 00:01 armed; time sits at 00:00:00 on a tick boundary
    press(B_MODE);
    press(B_UP);
    chk("armed", 32'(alEn4), 32'h1);
    press(B_SET);
    chk("set alarm mode", 32'(mode4), 32'd4);
    pressN(B_NEXT, 3);
    press(B_UP);
    press(B_SET);
    chk("alarm mode", 32'(mode4), 32'd1);
    chk("alarm disp4", 32'(disp4), 32'h0001);
    chk("alarm disp6", 32'(disp6), 32'h000100);
    press(B_MODE);
    chk("sw mode", 32'(mode4), 32'd2);
    cyc(230);
    chk("beep before", 32'({beep4, beep6}), 32'h0);
    cyc(1);
    chk("beep on", 32'({beep4, beep6}), 32'h3);
    press(B_SS);
    chk("beep cleared", 32'({beep4, beep6}), 32'h0);
    cyc(8);
    chk("sw not started", 32'(disp4), 32'h0000);

    // Stopwatch run, lap freeze, stop and clear
    press(B_SS);
    cyc(10);
    chk("sw 3", 32'(disp4), 32'h0003);
    press(B_LAP);
    cyc(7);
    chk("lap4 held", 32'(disp4), 32'h0003);
    chk("lap6 held", 32'(disp6), 32'h000003);
    press(B_LAP);
    chk("live 5", 32'(disp4), 32'h0005);
    press(B_SS);
    chk("stopped 5", 32'(disp4), 32'h0005);
    press(B_LAP);
    chk("clear4", 32'(disp4), 32'h0000);
    chk("clear6", 32'(disp6), 32'h000000);

    // Run to 99:59 (5999 s), then one more second
    press(B_SS);
    cyc(23996);
    chk("sw4 9959", 32'(disp4), 32'h9959);
    chk("sw6 013959", 32'(disp6), 32'h013959);
    cyc(4);
    chk("sw4 wrap", 32'(disp4), 32'h0000);
    chk("sw6 014000", 32'(disp6), 32'h014000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
Parametrised watch controller for the watch top level. It integrates a time-of-day clock, an alarm, a background stopwatch and a cursor-based time-set editor behind a single mode state machine. It presents BCD digits plus a blink mask to the existing per-digit seven-segment decoders. Button inputs arrive as debounced single-cycle pulses.

Parameters:
TICK_DIV, 50000000, clk cycles per second (minimum 4; even)
NUM_DIGITS, 4, displayed digits: 4 = HH:MM (stopwatch MM:SS), 6 = HH:MM:SS
BEEP_SECONDS, 60, maximum alarm beep duration in seconds

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
modeNext  in  1  pulse: cycle display mode
setValue  in  1  pulse: enter or commit set mode
nextDigit  in  1  pulse: advance edit cursor
upTime  in  1  pulse: increment cursor digit; in ALARM, toggle alarm enable
startStop  in  1  pulse: stopwatch run/stop
lapReset  in  1  pulse: stopwatch lap/clear
displayDigits  out  4*NUM_DIGITS  BCD digits, most significant digit first
blinkMask  out  NUM_DIGITS  1 = blank this digit
modeState  out  3  current mode encoding
alarmEnabled  out  1  alarm armed
alarmBeep  out  1  beep request

Behaviour:
- Reset (async, resetN=0): mode CLOCK; time 00:00:00; alarm 00:00 disarmed; stopwatch 0, stopped, no lap; prescaler 0; all outputs 0.
- Prescaler: counts 0..TICK_DIV-1. secTick is asserted on the wrap cycle. blinkPhase toggles at count TICK_DIV/2-1 and on wrap.
- Time-of-day advances on secTick in every mode. BCD cascade ss→mm→hh; 23:59:59 → 00:00:00.
- Modes: CLOCK=0, ALARM=1, STOPWATCH=2, SET_CLOCK=3, SET_ALARM=4.
  - modeNext: CLOCK→ALARM→STOPWATCH→CLOCK. Ignored in SET states.
  - setValue in CLOCK → SET_CLOCK. setValue in ALARM → SET_ALARM. Entering a SET state copies the source HH:MM into a shadow register and sets cursor=0.
  - setValue in a SET state commits the shadow and returns to the originating mode.
  - SET_CLOCK commit writes HH:MM, clears ss and the prescaler.
- Same-cycle button priority: setValue > modeNext > nextDigit > upTime > startStop > lapReset. Lower-priority pulses in that cycle are dropped.
- Editing (SET states only):
  - nextDigit: cursor 0→1→2→3→0 (hour tens, hour ones, minute tens, minute ones).
  - upTime increments the selected digit with wrap to 0. Limits: hour tens 0-2; hour ones 0-9, or 0-3 when hour tens=2; minute tens 0-5; minute ones 0-9.
  - When hour tens becomes 2 and hour ones >3, hour ones is forced to 3 in the same cycle.
- blinkMask: in SET states, the cursor digit bit equals blinkPhase; all other bits are 0. Outside SET states, blinkMask=0.
- Alarm:
  - upTime in ALARM toggles alarmEnabled.
  - Triggers on a secTick that causes the time to become alarm HH:MM:00 while armed and mode≠SET_CLOCK.
  - alarmBeep=1 from the cycle after the trigger tick. It clears after BEEP_SECONDS secTicks, or on the cycle after any button pulse (that pulse then has no other effect).
  - Disarming while beeping clears the beep next cycle.
- Stopwatch:
  - Counts on secTick while running, in any mode.
  - startStop toggles run, honoured only in STOPWATCH mode.
  - lapReset in STOPWATCH mode: if running, toggles the lap freeze (display holds the captured value while counting continues). If stopped, clears count and lap.
  - 4-digit mode: count wraps 99:59 → 00:00. 6-digit mode: 99:59:59 → 00:00:00.
- Display per mode:
  - CLOCK: time.
  - ALARM: alarm HH:MM (ss digits 0 when NUM_DIGITS=6).
  - STOPWATCH: lap or live count.
  - SET states: shadow value.
- Outputs are registered; 1-cycle latency from input pulse to output change.

Decomposition:
- watch_pkg: mode encodings, cursor indices, BCD digit limits, width function 4*NUM_DIGITS.
- Sub-module bcd_time_counter (inc, load, loadValue, maxHours parameter 23/99, carry out). Instantiated twice: once for time-of-day, once for the stopwatch.

Test Plan (TICK_DIV=4):
- Reset mid-count at time 12:34:56 → all outputs 0 asynchronously; after release, digits read 0000.
- Load 23:59:59 via SET_CLOCK plus ticks, then one secTick → time 00:00:00; 6-digit display shows 000000.
- SET_CLOCK: hour ones set to 9, then hour tens incremented to 2 → shadow 23. Commit → CLOCK shows 2300 and ss=0.
- Alarm 00:01 armed, time 00:00:59 → alarmBeep=1 the cycle after the tick. A startStop pulse clears the beep; the stopwatch does not start.
- Stopwatch: start, 3 ticks, lap, 2 ticks → display 0003 while the internal count is 5. Lap again → 0005. Stop, lapReset → 0000.
- Same-cycle setValue+modeNext in CLOCK → SET_CLOCK entered; modeNext dropped.
